// File: rtl/div_pkg.sv
// Shared divider definitions: default sizes, result-tag layout and the
// saturation values substituted for divide-by-zero results.
package div_pkg;

  localparam int DIV_QUOTIENT = 32;
  localparam int DIV_DEPTH    = 8;
  localparam int DIV_QMAX     = 64;

  typedef struct packed {
    logic neg;
    logic dz;
  } div_tag_t;

  typedef enum logic [1:0] {
    CORR_PASS,
    CORR_NEGATE,
    CORR_SAT_POS,
    CORR_SAT_NEG
  } div_corr_e;

  // Divide-by-zero takes priority over sign correction.
  function automatic div_corr_e divCorrSelect(input div_tag_t tag);
    if (tag.dz && !tag.neg) return CORR_SAT_POS;
    if (tag.dz) return CORR_SAT_NEG;
    if (tag.neg) return CORR_NEGATE;
    return CORR_PASS;
  endfunction

  function automatic logic [DIV_QMAX-1:0] divSatPos(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [DIV_QMAX-1:0] divSatNeg(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/div_result_buffer_if.sv
// Issue, divider-return and result-output signals of the divider result buffer.
interface div_result_buffer_if import div_pkg::*; #(
  parameter int QUOTIENT = DIV_QUOTIENT
);

  logic                issue_valid;
  logic                issue_neg;
  logic                issue_dz;
  logic                issue_ready;
  logic                div_ovalid;
  logic [QUOTIENT-1:0] div_quotient;
  logic                m_valid;
  logic                m_ready;
  logic [QUOTIENT-1:0] m_quotient;
  logic                m_dz;
  logic                err;

  modport master (
    output issue_valid, issue_neg, issue_dz, div_ovalid, div_quotient, m_ready,
    input  issue_ready, m_valid, m_quotient, m_dz, err
  );

  modport slave (
    input  issue_valid, issue_neg, issue_dz, div_ovalid, div_quotient, m_ready,
    output issue_ready, m_valid, m_quotient, m_dz, err
  );

endinterface

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; pushes into a full FIFO and pops from an empty
// one are ignored, simultaneous push and pop are both performed.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       pushData_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       popData_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [PW:0]      count_q, count_d;
  logic             doPush, doPop;

  assign full_o    = (count_q == (PW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign popData_o = mem_q[rdPtr_q];
  assign doPush    = push_i && !full_o;
  assign doPop     = pop_i && !empty_o;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + 1'b1;
    if (doPop) rdPtr_d = rdPtr_q + 1'b1;
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clock) begin
    if (doPush) mem_q[wrPtr_q] <= pushData_i;
  end

endmodule

// File: rtl/div_result_buffer.sv
// Restores flow control around a backpressure-free pipelined divider: credits
// gate issue, tags follow each division in order and results are sign-corrected.
module div_result_buffer import div_pkg::*; #(
  parameter int QUOTIENT = DIV_QUOTIENT,
  parameter int DEPTH    = DIV_DEPTH
) (
  input logic               clock,
  input logic               reset,
  div_result_buffer_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 2;
  localparam logic [DIV_QMAX-1:0] SAT_POS_FULL = divSatPos(QUOTIENT);
  localparam logic [DIV_QMAX-1:0] SAT_NEG_FULL = divSatNeg(QUOTIENT);
  localparam logic [QUOTIENT-1:0] SAT_POS = SAT_POS_FULL[QUOTIENT-1:0];
  localparam logic [QUOTIENT-1:0] SAT_NEG = SAT_NEG_FULL[QUOTIENT-1:0];

  div_tag_t            issueTag, headTag;
  logic                issueReady, issueAccept, handshake;
  logic                tagPop, tagFull, tagEmpty;
  logic [CW-1:0]       tagCount;
  logic                resPush, resPop, resFull, resEmpty;
  logic [CW-1:0]       resCount;
  logic [QUOTIENT:0]   resPushData, resHeadData;
  logic [QUOTIENT-1:0] corrQuotient;
  logic                loadOut, accountingBad;

  logic [CW-1:0]       outstanding_q, outstanding_d;
  logic                mValid_q, mValid_d;
  logic [QUOTIENT-1:0] mQuotient_q, mQuotient_d;
  logic                mDz_q, mDz_d;
  logic                err_q, err_d;

  assign issueReady  = (outstanding_q < CW'(DEPTH));
  assign issueAccept = bus.issue_valid && issueReady;
  assign handshake   = mValid_q && bus.m_ready;
  assign issueTag    = '{neg: bus.issue_neg, dz: bus.issue_dz};

  // The tag FIFO's empty flag is registered, so a same-cycle push is never consumed.
  assign tagPop      = bus.div_ovalid && !tagEmpty;
  assign resPush     = tagPop;
  assign resPushData = {headTag.dz, corrQuotient};
  assign loadOut     = !mValid_q || bus.m_ready;
  assign resPop      = loadOut && !resEmpty;

  sync_fifo #(
    .WIDTH($bits(div_tag_t)),
    .DEPTH(DEPTH)
  ) tagFifo (
    .clock     (clock),
    .reset     (reset),
    .push_i    (issueAccept),
    .pushData_i(issueTag),
    .pop_i     (tagPop),
    .popData_o (headTag),
    .full_o    (tagFull),
    .empty_o   (tagEmpty),
    .count_o   (tagCount)
  );

  sync_fifo #(
    .WIDTH(QUOTIENT + 1),
    .DEPTH(DEPTH)
  ) resultFifo (
    .clock     (clock),
    .reset     (reset),
    .push_i    (resPush),
    .pushData_i(resPushData),
    .pop_i     (resPop),
    .popData_o (resHeadData),
    .full_o    (resFull),
    .empty_o   (resEmpty),
    .count_o   (resCount)
  );

  always_comb begin
    corrQuotient = bus.div_quotient;
    case (divCorrSelect(headTag))
      CORR_SAT_POS: corrQuotient = SAT_POS;
      CORR_SAT_NEG: corrQuotient = SAT_NEG;
      CORR_NEGATE:  corrQuotient = ~bus.div_quotient + 1'b1;
      default:      corrQuotient = bus.div_quotient;
    endcase
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (issueAccept && !handshake) outstanding_d = outstanding_q + 1'b1;
    else if (!issueAccept && handshake) outstanding_d = outstanding_q - 1'b1;
  end

  // Every credited division lives in exactly one place: tag FIFO, result FIFO or output.
  assign accountingBad = (SW'(tagCount) + SW'(resCount) + SW'(mValid_q)) > SW'(outstanding_q);

  always_comb begin
    mValid_d    = mValid_q;
    mQuotient_d = mQuotient_q;
    mDz_d       = mDz_q;
    if (loadOut) begin
      mValid_d = !resEmpty;
      if (!resEmpty) begin
        mQuotient_d = resHeadData[QUOTIENT-1:0];
        mDz_d       = resHeadData[QUOTIENT];
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (bus.issue_valid && !issueReady) err_d = 1'b1;
    if (bus.div_ovalid && tagEmpty) err_d = 1'b1;
    if (resPush && resFull) err_d = 1'b1;
    if (issueAccept && tagFull) err_d = 1'b1;
    if (accountingBad) err_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outstanding_q <= '0;
      mValid_q      <= 1'b0;
      mQuotient_q   <= '0;
      mDz_q         <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      mValid_q      <= mValid_d;
      mQuotient_q   <= mQuotient_d;
      mDz_q         <= mDz_d;
      err_q         <= err_d;
    end
  end

  assign bus.issue_ready = issueReady;
  assign bus.m_valid     = mValid_q;
  assign bus.m_quotient  = mQuotient_q;
  assign bus.m_dz        = mDz_q;
  assign bus.err         = err_q;

endmodule
